// File: rtl/booth_pp_sequencer.sv
// Sequential radix-4 Booth partial-product generator feeding a Wallace tree.
// One Booth digit of B is recoded per cycle; results are held until the tree takes them.
module booth_pp_sequencer #(
    parameter int MBITS = 12,
    parameter int NBITS = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [MBITS-1:0] a_in,
    input  logic [NBITS-1:0] b_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [MBITS:0]   pp0,
    output logic [MBITS:0]   pp1,
    output logic [MBITS:0]   pp2,
    output logic [MBITS:0]   pp3,
    output logic [3:0]       neg,
    output logic             busy
);

    localparam int NPP = NBITS / 2;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] GEN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [1:0]       cnt;
    logic [MBITS-1:0] a_reg;
    logic [NBITS-1:0] b_reg;
    logic [MBITS:0]   pp_reg [4];
    logic [3:0]       neg_reg;
    logic             valid_reg;

    logic [NBITS:0]   b_ext;
    logic [2:0]       triplet;
    logic [MBITS:0]   ax;
    logic [MBITS:0]   ax2;
    logic [MBITS:0]   pp_next;
    logic             neg_next;

    // B[-1] is an implicit zero below the LSB of the multiplier.
    assign b_ext   = {b_reg, 1'b0};
    assign triplet = b_ext[{cnt, 1'b0} +: 3];
    assign ax      = {a_reg[MBITS-1], a_reg};
    assign ax2     = {a_reg, 1'b0};

    // Negative digits use one's complement here; the +1 travels separately on neg.
    always_comb begin
        pp_next  = '0;
        neg_next = 1'b0;
        case (triplet)
            3'b001, 3'b010: begin
                pp_next  = ax;
                neg_next = 1'b0;
            end
            3'b011: begin
                pp_next  = ax2;
                neg_next = 1'b0;
            end
            3'b100: begin
                pp_next  = ~ax2;
                neg_next = 1'b1;
            end
            3'b101, 3'b110: begin
                pp_next  = ~ax;
                neg_next = 1'b1;
            end
            default: begin
                pp_next  = '0;
                neg_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            pp_reg[0] <= '0;
            pp_reg[1] <= '0;
            pp_reg[2] <= '0;
            pp_reg[3] <= '0;
            neg_reg   <= '0;
            valid_reg <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg <= a_in;
                        b_reg <= b_in;
                        cnt   <= '0;
                        state <= GEN;
                    end
                end
                GEN: begin
                    pp_reg[cnt]  <= pp_next;
                    neg_reg[cnt] <= neg_next;
                    cnt          <= cnt + 2'd1;
                    if (cnt == 2'(NPP - 1)) begin
                        valid_reg <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        valid_reg <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    valid_reg <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    // in_ready is gated by rst_n so every output reads zero while reset is held.
    assign in_ready  = rst_n && (state == IDLE);
    assign busy      = (state == GEN) || (state == DONE);
    assign out_valid = valid_reg;
    assign pp0       = pp_reg[0];
    assign pp1       = pp_reg[1];
    assign pp2       = pp_reg[2];
    assign pp3       = pp_reg[3];
    assign neg       = neg_reg;

endmodule

// File: tb/tb_booth_pp_sequencer.sv
// Self-checking bench for booth_pp_sequencer: directed vectors plus a Booth-digit
// arithmetic model that checks every presented result and the corrected-sum identity.
module tb_booth_pp_sequencer;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] a_in;
    logic [7:0]  b_in;
    logic        out_valid;
    logic        out_ready;
    logic [12:0] pp0, pp1, pp2, pp3;
    logic [3:0]  neg;
    logic        busy;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic [11:0] a;
        logic [7:0]  b;
    } op_t;

    op_t pending[$];

    booth_pp_sequencer #(.MBITS(12), .NBITS(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_in      (a_in),
        .b_in      (b_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pp0       (pp0),
        .pp1       (pp1),
        .pp2       (pp2),
        .pp3       (pp3),
        .neg       (neg),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input longint act, input longint exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    function automatic longint sx13(input logic [12:0] v);
        logic signed [12:0] t;
        t = v;
        return longint'(t);
    endfunction

    // Booth digit value d = -2*b[2i+1] + b[2i] + b[2i-1]; a negative digit is presented
    // as d*A - 1 (one's complement of |d|*A) with the missing 1 flagged on neg.
    task automatic model_pp(input logic [11:0] a, input logic [7:0] b, input int i,
                            output logic [12:0] pp, output logic ng);
        logic signed [11:0] as;
        int d, lo, pv;
        as = a;
        lo = (i == 0) ? 0 : int'(b[2*i-1]);
        d  = -2 * int'(b[2*i+1]) + int'(b[2*i]) + lo;
        if (d < 0) begin
            pv = d * int'(as) - 1;
            ng = 1'b1;
        end else begin
            pv = d * int'(as);
            ng = 1'b0;
        end
        pp = pv[12:0];
    endtask

    // Compare process: every cycle a result is presented it must match the oldest accepted op.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (pending.size() == 0) begin
                check_output("unexpected_out_valid", 1, 0);
            end else begin
                logic [12:0] e_pp [4];
                logic        e_ng [4];
                logic [12:0] got [4];
                logic signed [11:0] as;
                logic signed [7:0]  bs;
                longint sum;
                op_t op;
                op = pending[0];
                got[0] = pp0; got[1] = pp1; got[2] = pp2; got[3] = pp3;
                sum = 0;
                for (int i = 0; i < 4; i++) begin
                    model_pp(op.a, op.b, i, e_pp[i], e_ng[i]);
                    check_output($sformatf("model_pp%0d", i), longint'(got[i]), longint'(e_pp[i]));
                    check_output($sformatf("model_neg%0d", i), longint'(neg[i]), longint'(e_ng[i]));
                    sum += (sx13(got[i]) + longint'(neg[i])) * (longint'(1) << (2 * i));
                end
                as = op.a;
                bs = op.b;
                check_output("corrected_sum", sum, longint'(as) * longint'(bs));
                if (out_ready) void'(pending.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [11:0] a, input logic [7:0] b, input bit ready_early);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        check_output("accept_in_ready", longint'(in_ready), 1);
        pending.push_back('{a: a, b: b});
        in_valid  = 1'b1;
        a_in      = a;
        b_in      = b;
        out_ready = ready_early;
        tick();
        in_valid = 1'b0;
        a_in     = 12'($urandom);
        b_in     = 8'($urandom);
        check_output("gen_busy", longint'(busy), 1);
        check_output("gen_in_ready", longint'(in_ready), 0);
        check_output("latency_e0", longint'(out_valid), 0);
        for (int k = 1; k <= 3; k++) begin
            tick();
            a_in = 12'($urandom);
            b_in = 8'($urandom);
            check_output($sformatf("latency_e%0d", k), longint'(out_valid), 0);
        end
        tick();
        out_ready = 1'b0;
        check_output("latency_e4", longint'(out_valid), 1);
    endtask

    task automatic finish_op(input int stall);
        for (int k = 0; k < stall; k++) begin
            check_output("hold_out_valid", longint'(out_valid), 1);
            check_output("hold_in_ready", longint'(in_ready), 0);
            check_output("hold_busy", longint'(busy), 1);
            a_in = 12'($urandom);
            b_in = 8'($urandom);
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_output("release_out_valid", longint'(out_valid), 0);
        check_output("release_busy", longint'(busy), 0);
        check_output("release_in_ready", longint'(in_ready), 1);
    endtask

    task automatic check_literals(input string tag, input logic [12:0] e0, input logic [12:0] e1,
                                  input logic [12:0] e2, input logic [12:0] e3, input logic [3:0] en);
        check_output({tag, "_pp0"}, longint'(pp0), longint'(e0));
        check_output({tag, "_pp1"}, longint'(pp1), longint'(e1));
        check_output({tag, "_pp2"}, longint'(pp2), longint'(e2));
        check_output({tag, "_pp3"}, longint'(pp3), longint'(e3));
        check_output({tag, "_neg"}, longint'(neg), longint'(en));
    endtask

    task automatic check_all_zero(input string tag);
        check_output({tag, "_out_valid"}, longint'(out_valid), 0);
        check_output({tag, "_in_ready"}, longint'(in_ready), 0);
        check_output({tag, "_busy"}, longint'(busy), 0);
        check_literals(tag, 13'h0, 13'h0, 13'h0, 13'h0, 4'h0);
    endtask

    task automatic apply_stimulus();
        // Reset state
        #2;
        check_all_zero("reset");
        tick();
        rst_n = 1'b1;
        #1;
        check_output("post_reset_in_ready", longint'(in_ready), 1);

        start_op(12'd100, 8'd3, 1'b0);
        check_literals("t1", 13'h1F9B, 13'h0064, 13'h0000, 13'h0000, 4'b0001);
        finish_op(0);

        start_op(12'hFFF, 8'h80, 1'b0);
        check_literals("t2", 13'h0000, 13'h0000, 13'h0000, 13'h0001, 4'b1000);
        finish_op(1);

        // Long hold with toggling inputs; outputs must still show the original op.
        start_op(12'h7FF, 8'h7F, 1'b0);
        finish_op(10);
        check_output("t4_pp0_after_hold", longint'(pp0), longint'(13'h1800));
        check_output("t4_pp3_after_hold", longint'(pp3), longint'(13'h0FFE));

        start_op(12'h800, 8'h80, 1'b1);
        check_literals("extreme", 13'h0000, 13'h0000, 13'h0000, 13'h0FFF, 4'b1000);
        finish_op(2);

        // Reset arrives mid-generation after two digits have been written.
        pending.push_back('{a: 12'd77, b: 8'h5A});
        in_valid = 1'b1;
        a_in     = 12'd77;
        b_in     = 8'h5A;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("midgen_reset");
        pending.delete();
        tick();
        rst_n = 1'b1;
        #1;
        start_op(12'd5, 8'd2, 1'b0);
        check_literals("t5", 13'h1FF5, 13'h0005, 13'h0000, 13'h0000, 4'b0001);
        finish_op(0);

        for (int n = 0; n < 1000; n++) begin
            start_op(12'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
            finish_op(int'($urandom_range(0, 3)));
        end
        check_output("queue_drained", longint'(pending.size()), 0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a_in      = '0;
        b_in      = '0;
        apply_stimulus();
        repeat (2) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
